// File: rtl/spi_slave_only_rx_single_cs.sv
// Receive-only SPI slave (mode 0, MSB first, CS active-low) that oversamples the
// SPI pins in the clk_i domain and presents each completed word with a one-cycle strobe.
//
// state      | meaning
// ST_IDLE    | CS (synchronized) high; clock edges ignored
// ST_RECEIVE | CS low; shifting MOSI on each synchronized SPI clock rise
module spi_slave_only_rx_single_cs #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  spi_clk_i,
  input  logic                  spi_mosi_i,
  input  logic                  spi_cs_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  data_valid_strobe_o,
  output logic                  frame_error_strobe_o,
  output logic                  busy_o
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic {ST_IDLE, ST_RECEIVE} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic                   sclk_q, sclk_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic                   pend_q, pend_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;

  logic sclk_s, mosi_s, cs_s, rise;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_q;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_i};
    sclk_d      = sclk_s;
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    pend_d      = 1'b0;
    valid_d     = 1'b0;
    err_d       = 1'b0;

    // A word completed last cycle is published even if CS has since gone high;
    // shift_q is only cleared on the next IDLE->RECEIVE entry, after this read.
    if (pend_q) begin
      data_d  = shift_q;
      valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (!cs_s) begin
          state_d = ST_RECEIVE;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      ST_RECEIVE: begin
        if (rise) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], mosi_s};
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            cnt_d  = '0;
            pend_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (cs_s) begin
          state_d = ST_IDLE;
          err_d   = (cnt_d != '0);
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RECEIVE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_q      <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      pend_q      <= 1'b0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_sync_q   <= cs_sync_d;
      sclk_q      <= sclk_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign data_o               = data_q;
  assign data_valid_strobe_o  = valid_q;
  assign frame_error_strobe_o = err_q;
  assign busy_o               = busy_q;

endmodule

// File: tb/tb_spi_slave_only_rx_single_cs.sv
// Scoreboard bench for the receive-only SPI slave: stimulus pushes expected words or
// frame errors, a negedge monitor pops and compares whenever a strobe appears.
module tb_spi_slave_only_rx_single_cs;

  localparam int DW = 8;
  localparam int SS = 2;

  typedef struct {
    bit           is_err;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, sclk, mosi, cs;
  logic [DW-1:0] data_o;
  logic          dvs, fes, busy;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   lat_armed = 1'b0;
  int   last_rise_cyc = 0;
  int   lat_exp_cyc   = 0;
  logic [DW-1:0] last_data = '0;

  spi_slave_only_rx_single_cs #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .clk_i(clk), .rst_i(rst), .spi_clk_i(sclk), .spi_mosi_i(mosi), .spi_cs_i(cs),
    .data_o(data_o), .data_valid_strobe_o(dvs), .frame_error_strobe_o(fes), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = '0;
    exp_q.push_back(e);
  endtask

  // Sends the top n bits of b, MSB first, spi_clk = clk/4; optionally raises CS with the last rise.
  task automatic send_bits(input logic [DW-1:0] b, input int n, input bit cs_on_last);
    for (int i = DW - 1; i >= DW - n; i--) begin
      mosi = b[i];
      sclk = 1'b0;
      tick(2);
      sclk = 1'b1;
      last_rise_cyc = cyc + 1;
      if (cs_on_last && i == DW - n) cs = 1'b1;
      tick(2);
    end
    sclk = 1'b0;
  endtask

  task automatic frame_start();
    cs = 1'b0;
    tick(4);
    check("busy_in_frame", busy, 1'b1);
  endtask

  task automatic frame_end();
    tick(2);
    cs = 1'b1;
    tick(8);
    check("busy_after_frame", busy, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_data = '0;
    end else begin
      if (dvs && fes) begin
        n_checks++;
        n_fail++;
        $display("FAIL both_strobes: data and error strobes high together");
      end
      if (dvs) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_data_strobe: data_o=%0h, nothing expected", data_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_kind_is_data", {31'd0, e.is_err}, 32'd0);
          check("data_word", data_o, e.data);
        end
        if (lat_armed) begin
          check("strobe_latency_cycle", cyc, lat_exp_cyc);
          lat_armed = 1'b0;
        end
        last_data = data_o;
      end else begin
        check("data_hold", data_o, last_data);
      end
      if (fes) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame_error: no error expected");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_kind_is_error", {31'd0, e.is_err}, 32'd1);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1;
    tick(4);
    check("reset_data", data_o, '0);
    check("reset_valid", dvs, 1'b0);
    check("reset_err", fes, 1'b0);
    check("reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick(4);

    // 1: clock activity with CS high is ignored
    send_bits(8'hFF, 8, 1'b0);
    tick(8);
    check("idle_toggle_data", data_o, '0);
    check("idle_toggle_busy", busy, 1'b0);

    // 2: single word with latency check
    frame_start();
    push_word(8'hA5);
    lat_armed = 1'b1;
    send_bits(8'hA5, 8, 1'b0);
    lat_exp_cyc = last_rise_cyc + SS + 1;
    frame_end();
    check("latency_checked", {31'd0, lat_armed}, 32'd0);

    // 3: back-to-back words under one CS
    frame_start();
    push_word(8'h3C); send_bits(8'h3C, 8, 1'b0);
    push_word(8'hFF); send_bits(8'hFF, 8, 1'b0);
    push_word(8'h01); send_bits(8'h01, 8, 1'b0);
    frame_end();
    check("after_b2b_data", data_o, 8'h01);

    // 4: CS released after 5 bits -> frame error, data held
    frame_start();
    push_err();
    send_bits(8'hF0, 5, 1'b0);
    frame_end();
    check("after_err_data", data_o, 8'h01);

    // 6: last rise coincides with CS release -> word delivered, no error
    frame_start();
    push_word(8'h5A);
    send_bits(8'h5A, 8, 1'b1);
    tick(10);
    check("cs_with_last_data", data_o, 8'h5A);
    check("cs_with_last_busy", busy, 1'b0);

    // 5: reset mid-word discards partial, next frame clean
    frame_start();
    send_bits(8'hF0, 4, 1'b0);
    rst = 1'b1;
    cs = 1'b1;
    tick(3);
    check("midword_reset_data", data_o, '0);
    check("midword_reset_busy", busy, 1'b0);
    rst = 1'b0;
    tick(4);
    frame_start();
    push_word(8'h81);
    send_bits(8'h81, 8, 1'b0);
    frame_end();
    check("after_reset_word", data_o, 8'h81);

    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick(1);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
